// File: rtl/demux1_2_pkg.sv
// Shared types and constants for the 1-to-2 packet-locked stream demultiplexer.
package demux_pkg;

    // Route FSM: no packet open, or packet open and locked to one output
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } route_state_t;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    // Lock state that corresponds to a given destination channel
    function automatic route_state_t lock_of(input logic ch);
        return (ch == CH1) ? LOCK1 : LOCK0;
    endfunction

endpackage

// File: rtl/demux1_2_out_stage.sv
// One-entry registered output slice: holds a single beat until downstream
// takes it, and flags when the beat leaving is the last of its packet.
module out_stage
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d_data,
    input  logic             d_last,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             last,
    input  logic             ready,
    output logic             rdy,
    output logic             done_pkt
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic             last_q,  last_d;
    logic             drain;

    assign drain    = valid_q & ready;
    assign rdy      = ~valid_q | ready;
    assign done_pkt = drain & last_q;

    assign valid = valid_q;
    assign data  = data_q;
    assign last  = last_q;

    // Next-state: drain clears valid, a load (possibly in the same cycle) refills it
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (drain) begin
            valid_d = 1'b0;
        end
        if (load) begin
            valid_d = 1'b1;
            data_d  = d_data;
            last_d  = d_last;
        end
    end

    // Slice register; reset discards any held beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: rtl/demux1_2.sv
// Stream 1-to-2 demultiplexer. The select is sampled on the first beat of a
// packet and held until its last beat, so every packet goes whole to one
// output. Each output has its own register slice, so a stall on one side
// never blocks traffic routed to the other.
module demux1_2
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_last,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_last,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [7:0]       pkt0_cnt,
    output logic [7:0]       pkt1_cnt
);

    route_state_t state_q, state_d;
    logic [7:0]   pkt0_q, pkt0_d;
    logic [7:0]   pkt1_q, pkt1_d;

    logic target;
    logic rdy0, rdy1;
    logic accept;
    logic load0, load1;
    logic done0, done1;

    // Target is the live select only between packets; mid-packet it is the lock.
    // in_ready deliberately follows in_sel/outx_ready combinationally.
    always_comb begin
        target = in_sel;
        unique case (state_q)
            IDLE:    target = in_sel;
            LOCK0:   target = CH0;
            LOCK1:   target = CH1;
            default: target = in_sel;
        endcase
    end

    assign in_ready = (target == CH1) ? rdy1 : rdy0;
    assign accept   = in_valid & in_ready;
    assign load0    = accept & (target == CH0);
    assign load1    = accept & (target == CH1);

    out_stage #(.WIDTH(WIDTH)) u_stage0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load0),
        .d_data   (in_data),
        .d_last   (in_last),
        .valid    (out0_valid),
        .data     (out0_data),
        .last     (out0_last),
        .ready    (out0_ready),
        .rdy      (rdy0),
        .done_pkt (done0)
    );

    out_stage #(.WIDTH(WIDTH)) u_stage1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load1),
        .d_data   (in_data),
        .d_last   (in_last),
        .valid    (out1_valid),
        .data     (out1_data),
        .last     (out1_last),
        .ready    (out1_ready),
        .rdy      (rdy1),
        .done_pkt (done1)
    );

    // Route FSM next-state: only an accepted beat can open or close a packet
    always_comb begin
        state_d = state_q;
        if (accept) begin
            unique case (state_q)
                IDLE: begin
                    if (!in_last) begin
                        state_d = lock_of(in_sel);
                    end
                end
                LOCK0, LOCK1: begin
                    if (in_last) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Delivered-packet counters, wrapping modulo 256
    always_comb begin
        pkt0_d = pkt0_q;
        pkt1_d = pkt1_q;
        if (done0) begin
            pkt0_d = pkt0_q + 8'd1;
        end
        if (done1) begin
            pkt1_d = pkt1_q + 8'd1;
        end
    end

    // State and counter registers; reset drops any open lock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pkt0_q  <= 8'd0;
            pkt1_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            pkt0_q  <= pkt0_d;
            pkt1_q  <= pkt1_d;
        end
    end

    assign pkt0_cnt = pkt0_q;
    assign pkt1_cnt = pkt1_q;

endmodule

// File: tb/tb_demux1_2.sv
// Scoreboard bench for demux1_2: stimulus pushes expected beats per output,
// a monitor pops and compares whenever an output handshake completes.
module tb_demux1_2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_sel = 1'b0;
    logic       in_last = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out0_data, out1_data;
    logic       out0_last, out1_last;
    logic       out0_valid, out1_valid;
    logic       out0_ready = 1'b1;
    logic       out1_ready = 1'b1;
    logic [7:0] pkt0_cnt, pkt1_cnt;

    int checks = 0;
    int errors = 0;

    logic [8:0] exp0[$];
    logic [8:0] exp1[$];

    demux1_2 #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_last    (in_last),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_last  (out0_last),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_last  (out1_last),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .pkt0_cnt   (pkt0_cnt),
        .pkt1_cnt   (pkt1_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every completed output handshake must match the head of its queue
    always @(negedge clk) begin
        if (rst_n) begin
            if (out0_valid && out0_ready) begin
                if (exp0.size() == 0) begin
                    chk("out0_unexpected", {23'd0, out0_last, out0_data}, 32'h1FF);
                end else begin
                    logic [8:0] e;
                    e = exp0.pop_front();
                    chk("out0_beat", {23'd0, out0_last, out0_data}, {23'd0, e});
                end
            end
            if (out1_valid && out1_ready) begin
                if (exp1.size() == 0) begin
                    chk("out1_unexpected", {23'd0, out1_last, out1_data}, 32'h1FF);
                end else begin
                    logic [8:0] e;
                    e = exp1.pop_front();
                    chk("out1_beat", {23'd0, out1_last, out1_data}, {23'd0, e});
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge
    task automatic send(input logic [7:0] d, input logic sel, input logic last,
                        input logic exp_ch, input bit push, output int waits);
        bit done;
        in_valid = 1'b1;
        in_data  = d;
        in_sel   = sel;
        in_last  = last;
        waits    = 0;
        done     = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
                if (push) begin
                    if (exp_ch) exp1.push_back({last, d});
                    else        exp0.push_back({last, d});
                end
            end else begin
                waits++;
                if (waits > 50) begin
                    chk("send_timeout", 32'd0, 32'd1);
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        in_valid   = 1'b0;
        in_sel     = 1'b0;
        in_last    = 1'b0;
        in_data    = '0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        rst_n      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out0_valid", {31'd0, out0_valid}, 32'd0);
        chk("rst_out1_valid", {31'd0, out1_valid}, 32'd0);
        chk("rst_out0_data",  {24'd0, out0_data},  32'd0);
        chk("rst_out1_data",  {24'd0, out1_data},  32'd0);
        chk("rst_lasts",      {30'd0, out1_last, out0_last}, 32'd0);
        chk("rst_pkt0",       {24'd0, pkt0_cnt},   32'd0);
        chk("rst_pkt1",       {24'd0, pkt1_cnt},   32'd0);
        chk("rst_in_ready",   {31'd0, in_ready},   32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int w;

        // Reset mid-packet: lock toward out1 must be dropped
        do_reset();
        send(8'h11, 1'b1, 1'b0, 1'b1, 1'b1, w);
        send(8'h22, 1'b0, 1'b0, 1'b1, 1'b0, w);
        out1_ready = 1'b0;
        do_reset();
        send(8'h44, 1'b0, 1'b1, 1'b0, 1'b1, w);
        idle(3);
        chk("rstmid_pkt0", {24'd0, pkt0_cnt}, 32'd1);
        chk("rstmid_pkt1", {24'd0, pkt1_cnt}, 32'd0);

        // Packet lock: in_sel toggles every beat, all go to out0
        do_reset();
        send(8'hA1, 1'b0, 1'b0, 1'b0, 1'b1, w);
        send(8'hA2, 1'b1, 1'b0, 1'b0, 1'b1, w);
        send(8'hA3, 1'b0, 1'b0, 1'b0, 1'b1, w);
        send(8'hA4, 1'b1, 1'b1, 1'b0, 1'b1, w);
        @(negedge clk);
        chk("lock_latency", {23'd0, out0_last, out0_data}, {23'd0, 1'b1, 8'hA4});
        idle(3);
        chk("lock_pkt0", {24'd0, pkt0_cnt}, 32'd1);
        chk("lock_pkt1", {24'd0, pkt1_cnt}, 32'd0);

        // Back-to-back single-beat packets to different outputs
        do_reset();
        send(8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, w);
        chk("b2b_wait1", w, 32'd0);
        send(8'h6B, 1'b0, 1'b1, 1'b0, 1'b1, w);
        chk("b2b_wait2", w, 32'd0);
        idle(3);
        chk("b2b_pkt0", {24'd0, pkt0_cnt}, 32'd1);
        chk("b2b_pkt1", {24'd0, pkt1_cnt}, 32'd1);

        // Isolation: held beat on out1 does not block an out0 packet
        do_reset();
        out1_ready = 1'b0;
        send(8'h77, 1'b1, 1'b1, 1'b1, 1'b1, w);
        send(8'hB1, 1'b0, 1'b0, 1'b0, 1'b1, w);
        chk("iso_wait1", w, 32'd0);
        send(8'hB2, 1'b1, 1'b1, 1'b0, 1'b1, w);
        chk("iso_wait2", w, 32'd0);
        idle(2);
        chk("iso_out1_valid", {31'd0, out1_valid}, 32'd1);
        chk("iso_out1_data",  {24'd0, out1_data},  32'h77);
        chk("iso_pkt0",       {24'd0, pkt0_cnt},   32'd1);
        in_valid = 1'b1;
        in_sel   = 1'b1;
        in_last  = 1'b1;
        in_data  = 8'h88;
        @(negedge clk);
        chk("iso_blocked", {31'd0, in_ready}, 32'd0);
        in_sel = 1'b0;
        #1;
        chk("iso_sel_change", {31'd0, in_ready}, 32'd1);
        in_sel = 1'b1;
        #1;
        chk("iso_reblocked", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        out1_ready = 1'b1;
        send(8'h88, 1'b1, 1'b1, 1'b1, 1'b1, w);
        idle(3);
        chk("iso_pkt1", {24'd0, pkt1_cnt}, 32'd2);

        // Counter wrap
        do_reset();
        for (int i = 0; i < 256; i++) begin
            send(i[7:0], 1'b0, 1'b1, 1'b0, 1'b1, w);
        end
        idle(3);
        chk("wrap_256", {24'd0, pkt0_cnt}, 32'd0);
        send(8'hEE, 1'b0, 1'b1, 1'b0, 1'b1, w);
        idle(3);
        chk("wrap_257", {24'd0, pkt0_cnt}, 32'd1);
        chk("wrap_pkt1", {24'd0, pkt1_cnt}, 32'd0);

        chk("sb_empty0", exp0.size(), 32'd0);
        chk("sb_empty1", exp1.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux1_2.md
# demux1_2

Stream 1-to-2 demultiplexer with packet-locked routing. It is the receiving-end counterpart of the 2:1 select mux in the datapath library: a single valid/ready stream enters, and every packet is steered whole to output 0 or output 1. The select is sampled on the first beat of each packet and held until that packet's last beat. Each output has a one-entry registered stage, so a stall on one output never blocks traffic routed to the other.

## Interface
- WIDTH, 8, data width of every beat
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_data  input  WIDTH  input beat payload
- in_sel  input  1  destination (0 → out0, 1 → out1); sampled only on the first beat of a packet
- in_last  input  1  marks the final beat of a packet
- in_valid  input  1  input beat present
- in_ready  output  1  input beat accepted when in_valid & in_ready
- out0_data / out1_data  output  WIDTH  registered payload
- out0_last / out1_last  output  1  registered last flag
- out0_valid / out1_valid  output  1  output beat present
- out0_ready / out1_ready  input  1  downstream accepts the beat
- pkt0_cnt / pkt1_cnt  output  8  packets delivered per output; wraps 255 → 0

## Operation
- Route FSM states:
  - IDLE: no packet open.
  - LOCK0: packet open, routed to out0.
  - LOCK1: packet open, routed to out1.
- Target channel: in_sel while in IDLE; otherwise the locked channel. in_sel is ignored mid-packet.
- Transitions, on an accepted beat only:
  - IDLE, in_last=0 → LOCK(in_sel).
  - IDLE, in_last=1 → stay IDLE (single-beat packet).
  - LOCKx, in_last=1 → IDLE.
  - LOCKx, in_last=0 → stay LOCKx.
  - No accepted beat → no change.
- Stage x readiness: rdy_x = ~outx_valid | outx_ready.
- in_ready = rdy of the target channel. This gives a combinational path from in_sel and outx_ready to in_ready; that path is intentional.
- On an accepted beat, the target stage loads data and last and sets valid. The non-target stage is untouched.
- When a stage drains (outx_valid & outx_ready) and is not refilled in the same cycle, its valid clears. Drain and refill in the same cycle keeps valid at 1 with the new beat.
- pktx_cnt increments when outx_valid & outx_ready & outx_last. It wraps modulo 256.
- Reset values: FSM = IDLE; all outx_valid, outx_data, outx_last = 0; both counters = 0. in_ready then follows rdy, i.e. 1.
- Reset asserted mid-packet: held beats are discarded and the lock is dropped. Upstream is responsible for restarting the packet.

## Timing
- Latency: a beat accepted at edge N is on outx from edge N until it is accepted downstream.
- Throughput: 1 beat/cycle per packet when the target outx_ready is held high.
- Interleaving: out1 stalled with a held beat does not affect a packet routed to out0; in_ready tracks only rdy_0.
- A new packet whose target stage is full waits with in_ready = 0. Its in_sel may change while waiting, and the value present on the accepting cycle is the one that counts.
- The last beat of one packet and the first beat of the next may be accepted on consecutive cycles, to different outputs. No bubble is inserted.
- in_valid = 0 with in_ready = 1 is legal. No state changes.

## Structure
- Package demux_pkg holds:
  - the route_state_t enum {IDLE, LOCK0, LOCK1};
  - channel constants CH0 = 0, CH1 = 1.
- Sub-module out_stage is a one-entry register slice with ports clk, rst_n, load, d_data, d_last, valid, data, last, ready, rdy, done_pkt. It is instantiated twice.
- The top level holds the FSM, target/ready steering, and the two counters.

## Test plan
- Reset mid-packet: release reset, send 3-beat packet {0x11,0x22,0x33} sel=1 while toggling in_sel mid-packet, assert rst_n low after beat 2 → all valid = 0, counters = 0, FSM IDLE, and the next packet routes by its own in_sel.
- Packet lock: 4-beat packet {0xA1..0xA4} sel=0 with in_sel toggling every cycle and out0_ready = 1 → all 4 beats appear on out0 one cycle after acceptance, nothing on out1, pkt0_cnt = 1.
- Back-to-back: single-beat 0x5A sel=1, then single-beat 0x6B sel=0 on the next cycle → in_ready stays 1, out1 = 0x5A and out0 = 0x6B on consecutive edges, both counters = 1.
- Isolation: out1_ready = 0 with a held beat on out1, then a 2-beat packet sel=0 → out0 delivers both beats, out1 holds its beat unchanged, in_ready = 0 only when the sel=1 packet is presented.
- Wrap: 256 single-beat packets to out0 → pkt0_cnt reads 0; 257th → 1.
